// File: rtl/mult_div_ctrl.sv
// Iterative signed 32x32 multiply / 32/32 divide controller.
// One shift-add or restoring step per cycle on operand magnitudes.
module mult_div_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        FINISH
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [5:0]  count;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] opnd;
    logic        is_div;
    logic        dz;
    logic        neg_lo;
    logic        neg_hi;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic [63:0] prod_mag;
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;

    assign busy = (state != IDLE);

    always_comb begin
        mag_a     = op_a[31] ? (~op_a + 32'd1) : op_a;
        mag_b     = op_b[31] ? (~op_b + 32'd1) : op_b;
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : 32'd0)};
        div_shift = {acc_hi, acc_lo[31]};
        div_trial = div_shift - {1'b0, opnd};
        prod_mag  = {acc_hi, acc_lo};
        prod_s    = neg_lo ? (~prod_mag + 64'd1) : prod_mag;
        quo_s     = neg_lo ? (~acc_lo + 32'd1) : acc_lo;
        rem_s     = neg_hi ? (~acc_hi + 32'd1) : acc_hi;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_mult) begin
                    state_nx = MULT;
                end else if (start_div) begin
                    // A zero divisor skips the iterations entirely
                    state_nx = (op_b == 32'd0) ? FINISH : DIV;
                end
            end
            MULT, DIV: begin
                if (count == 6'd31) begin
                    state_nx = FINISH;
                end
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= 6'd0;
            acc_hi   <= 32'd0;
            acc_lo   <= 32'd0;
            opnd     <= 32'd0;
            is_div   <= 1'b0;
            dz       <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_nx;
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    count <= 6'd0;
                    if (start_mult) begin
                        acc_hi <= 32'd0;
                        acc_lo <= mag_b;
                        opnd   <= mag_a;
                        is_div <= 1'b0;
                        dz     <= 1'b0;
                        neg_lo <= op_a[31] ^ op_b[31];
                        neg_hi <= 1'b0;
                    end else if (start_div) begin
                        acc_hi <= 32'd0;
                        acc_lo <= mag_a;
                        opnd   <= mag_b;
                        is_div <= 1'b1;
                        dz     <= (op_b == 32'd0);
                        neg_lo <= op_a[31] ^ op_b[31];
                        neg_hi <= op_a[31];
                    end
                end
                MULT: begin
                    acc_hi <= mul_sum[32:1];
                    acc_lo <= {mul_sum[0], acc_lo[31:1]};
                    count  <= count + 6'd1;
                end
                DIV: begin
                    if (!div_trial[32]) begin
                        acc_hi <= div_trial[31:0];
                        acc_lo <= {acc_lo[30:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[31:0];
                        acc_lo <= {acc_lo[30:0], 1'b0};
                    end
                    count <= count + 6'd1;
                end
                FINISH: begin
                    done     <= 1'b1;
                    div_zero <= dz;
                    if (!dz) begin
                        if (is_div) begin
                            hi <= rem_s;
                            lo <= quo_s;
                        end else begin
                            hi <= prod_s[63:32];
                            lo <= prod_s[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed-vector bench for mult_div_ctrl.
// Results and done/busy timing checked against hand-computed values.
module tb_mult_div_ctrl;

    logic        clock;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int nvec = 0;
    int nerr = 0;

    mult_div_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs already set; the next rising edge is the accepting edge N.
    task automatic wait_result(input string tag, input logic [31:0] eh,
                               input logic [31:0] el, input logic edz,
                               input int lat);
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        check({tag, ".busy_n1"}, {31'd0, busy}, 32'd1);
        if (lat > 1) begin
            repeat (lat - 2) @(posedge clock);
            #1;
            check({tag, ".busy_pre"}, {31'd0, busy}, 32'd1);
            @(posedge clock);
            #1;
            check({tag, ".done_early"}, {31'd0, done}, 32'd0);
        end
        @(posedge clock);
        #1;
        check({tag, ".done"}, {31'd0, done}, 32'd1);
        check({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
        check({tag, ".div_zero"}, {31'd0, div_zero}, {31'd0, edz});
        check({tag, ".hi"}, hi, eh);
        check({tag, ".lo"}, lo, el);
        @(posedge clock);
        #1;
        check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, ".dz_pulse"}, {31'd0, div_zero}, 32'd0);
    endtask

    task automatic do_op(input string tag, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input logic edz, input int lat);
        @(negedge clock);
        start_mult = m;
        start_div  = d;
        op_a       = a;
        op_b       = b;
        wait_result(tag, eh, el, edz, lat);
    endtask

    initial begin
        int seen;
        reset      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = 32'd0;
        op_b       = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst.hi", hi, 32'd0);
        check("rst.lo", lo, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.dz", {31'd0, div_zero}, 32'd0);

        // First edge after release accepts a start
        @(negedge clock);
        reset      = 1'b1;
        start_mult = 1'b1;
        op_a       = 32'd7;
        op_b       = 32'hFFFF_FFFD;
        wait_result("mul7xm3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);

        do_op("div17_m5", 1'b0, 1'b1, 32'd17, 32'hFFFF_FFFB,
              32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        do_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
        do_op("mul_min_sq", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'd0, 1'b0, 33);
        do_op("div17_3", 1'b0, 1'b1, 32'd17, 32'd3,
              32'd2, 32'd5, 1'b0, 33);
        do_op("div_zero", 1'b0, 1'b1, 32'd99, 32'd0,
              32'd2, 32'd5, 1'b1, 1);

        // Operand changes must not disturb held results
        @(negedge clock);
        op_a = 32'h1234_5678;
        op_b = 32'h9ABC_DEF0;
        repeat (3) @(posedge clock);
        #1;
        check("hold.hi", hi, 32'd2);
        check("hold.lo", lo, 32'd5);

        do_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
              32'd0, 32'h8000_0000, 1'b0, 33);

        // Both starts: multiply wins; a later start_div is ignored
        @(negedge clock);
        start_mult = 1'b1;
        start_div  = 1'b1;
        op_a       = 32'd3;
        op_b       = 32'd4;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        start_div = 1'b1;
        op_a      = 32'd100;
        op_b      = 32'd7;
        @(posedge clock);
        #1;
        start_div = 1'b0;
        repeat (27) @(posedge clock);
        #1;
        check("both.done_early", {31'd0, done}, 32'd0);
        @(posedge clock);
        #1;
        check("both.done", {31'd0, done}, 32'd1);
        check("both.hi", hi, 32'd0);
        check("both.lo", lo, 32'd12);
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done || busy) seen++;
        end
        check("both.no_div", seen, 32'd0);

        // Reset at iteration 10 of a multiply
        @(negedge clock);
        start_mult = 1'b1;
        op_a       = 32'd9;
        op_b       = 32'd9;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("abort.hi", hi, 32'd0);
        check("abort.lo", lo, 32'd0);
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.done", {31'd0, done}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        seen  = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done || busy || hi != 0 || lo != 0) seen++;
        end
        check("abort.quiet", seen, 32'd0);
        do_op("mul5x6", 1'b1, 1'b0, 32'd5, 32'd6,
              32'd0, 32'd30, 1'b0, 33);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
